imem_loader: RTL and testbench

//  Writer side of the instruction memory. Receives a program image as a byte

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  // Loader FSM states; CHK is only reachable when checksumming is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  // First byte of every frame.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ============================================================================
//  Module      : byte_packer
//  Description : Collects four bytes (LSB first) into a 32-bit little-endian
//                word. word_full/word are valid in the cycle byte3 is taken.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift;

  // Byte counter and shift-in of the first three bytes of a word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= 2'd0;
      shift    <= 24'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      shift    <= 24'd0;
    end else if (take) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift    <= {byte_in, shift[23:8]};
    end
  end

  // The fourth byte completes the word combinationally so it can be
  // registered into the write port on the same edge it is accepted.
  always_comb begin
    word_full = take && (byte_cnt == 2'd3);
    word      = {byte_in, shift};
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Receives a program image as a byte stream framed as
//                SYNC, LEN_LO, LEN_HI, LEN*4 data bytes, writes the packed
//                words into instruction memory and holds the CPU in reset
//                until the image is loaded.
//                Build option: define LOADER_CHECKSUM_EN to require a
//                trailing XOR checksum byte after the data.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 65536
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        start,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_LAST = CHK;
`else
  localparam state_t AFTER_LAST = DONE;
`endif

  state_t      state;
  state_t      next_state;
  logic        xfer;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_in;
  logic [15:0] word_idx;
  logic        len_too_big;
  logic        last_word;
  logic        word_full;
  logic [31:0] packed_word;

  logic        mem_we_d;
  logic [31:0] mem_addr_d;
  logic [31:0] mem_wdata_d;
  logic        cpu_hold_d;
  logic        load_done_d;
  logic        load_err_d;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  xor_acc;
`endif

  assign xfer        = rx_valid && rx_ready;
  assign len_in      = {rx_data, len_lo};
  assign len_too_big = {16'd0, len_in} > MAX_WORDS_U;
  // 32-bit compare so word_idx+1 cannot overflow for len = 16'hFFFF.
  assign last_word   = ({16'd0, word_idx} + 32'd1) == {16'd0, len};

  byte_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (state == IDLE),
    .take      ((state == DATA) && xfer),
    .byte_in   (rx_data),
    .word_full (word_full),
    .word      (packed_word)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (xfer && (rx_data == SYNC_BYTE)) next_state = LEN_LO;
      LEN_LO: if (xfer) next_state = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (len_in == 16'd0)  next_state = AFTER_LAST;
          else if (len_too_big) next_state = ERROR;
          else                  next_state = DATA;
        end
      end
      DATA:   if (word_full) next_state = WRITE;
      WRITE:  next_state = last_word ? AFTER_LAST : DATA;
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) next_state = (rx_data == xor_acc) ? DONE : ERROR;
`else
        next_state = ERROR;
`endif
      end
      DONE:   if (start) next_state = IDLE;
      ERROR:  if (start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: rx_ready straight from state, everything else as the
  // value to be registered on the coming edge.
  always_comb begin
    rx_ready    = (state == IDLE) || (state == LEN_LO) || (state == LEN_HI) ||
                  (state == DATA) || (state == CHK);
    mem_we_d    = word_full;
    mem_addr_d  = word_full ? (BASE_ADDR + {14'd0, word_idx, 2'b00}) : mem_addr;
    mem_wdata_d = word_full ? packed_word : mem_wdata;
    load_done_d = (next_state == DONE);
    load_err_d  = (next_state == ERROR);
    cpu_hold_d  = (next_state != DONE);
  end

  // Registered outputs; the CPU is held until the image is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      load_done <= load_done_d;
      load_err  <= load_err_d;
      cpu_hold  <= cpu_hold_d;
    end
  end

  // Frame bookkeeping: length latch and word index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_lo   <= 8'd0;
      len      <= 16'd0;
      word_idx <= 16'd0;
    end else begin
      if (state == IDLE)            word_idx <= 16'd0;
      if (state == WRITE)           word_idx <= word_idx + 16'd1;
      if ((state == LEN_LO) && xfer) len_lo  <= rx_data;
      if ((state == LEN_HI) && xfer) len     <= len_in;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of data bytes, restarted for every frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    xor_acc <= 8'd0;
    else if (state == IDLE)          xor_acc <= 8'd0;
    else if ((state == DATA) && xfer) xor_acc <= xor_acc ^ rx_data;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader (MAX_WORDS=4).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic        clk;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        start;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  payload[$];

  imem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe seen between edges.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_byte timeout: byte %h rx_ready=%b required 1", b, rx_ready);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Sends SYNC, length and payload; optional idle gaps inside each word.
  task automatic send_frame(input logic [15:0] len, input bit gaps);
    logic [7:0] x;
    x = 8'h00;
    send_byte(8'hA5);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    foreach (payload[i]) begin
      if (gaps && (i % 4) == 2) repeat ($urandom_range(1, 4)) @(negedge clk);
      send_byte(payload[i]);
      x = x ^ payload[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({rx_ready, cpu_hold, load_done, load_err} !== 4'b1100) begin
      errors++;
      $display("FAIL start_rearm: rdy/hold/done/err=%b required 1100",
               {rx_ready, cpu_hold, load_done, load_err});
    end
  endtask

  task automatic load_prog2();
    payload = '{8'h93, 8'h00, 8'hB0, 8'h00, 8'h37, 8'h11, 8'h00, 8'h10};
  endtask

  // Checks the two writes and DONE status of the two-word program.
  task automatic check_prog2(input string tag);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr.size() !== 2) begin
      errors++;
      $display("FAIL %s write_count: got %0d required 2", tag, wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00B00093) begin
        errors++;
        $display("FAIL %s word0: got %h@%h required 00b00093@00000000", tag, wr_data[0], wr_addr[0]);
      end
      checks++;
      if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h10001137) begin
        errors++;
        $display("FAIL %s word1: got %h@%h required 10001137@00000004", tag, wr_data[1], wr_addr[1]);
      end
    end
    checks++;
    if ({load_done, cpu_hold, load_err, rx_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL %s done_state: done/hold/err/rdy=%b required 1000",
               tag, {load_done, cpu_hold, load_err, rx_ready});
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({cpu_hold, mem_we, rx_ready, load_done, load_err} !== 5'b10100) begin
      errors++;
      $display("FAIL reset_in: hold/we/rdy/done/err=%b required 10100",
               {cpu_hold, mem_we, rx_ready, load_done, load_err});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({cpu_hold, mem_we, rx_ready, load_done, load_err} !== 5'b10100 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: hold/we/rdy/done/err=%b addr=%h data=%h required 10100 0 0",
               {cpu_hold, mem_we, rx_ready, load_done, load_err}, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_basic();
    wr_addr.delete(); wr_data.delete();
    load_prog2();
    send_frame(16'd2, 1'b0);
    check_prog2("basic");
  endtask

  task automatic test_junk_and_gaps();
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    load_prog2();
    send_frame(16'd2, 1'b1);
    check_prog2("junk_gap");
  endtask

  task automatic test_zero_len();
    wr_addr.delete(); wr_data.delete();
    payload.delete();
    send_frame(16'd0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr.size() !== 0) begin
      errors++;
      $display("FAIL zero_len writes: got %0d required 0", wr_addr.size());
    end
    checks++;
    if ({load_done, cpu_hold, load_err} !== 3'b100) begin
      errors++;
      $display("FAIL zero_len state: done/hold/err=%b required 100", {load_done, cpu_hold, load_err});
    end
  endtask

  task automatic test_too_long();
    wr_addr.delete(); wr_data.delete();
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if ({load_err, cpu_hold, load_done, rx_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL too_long state: err/hold/done/rdy=%b required 1100",
               {load_err, cpu_hold, load_done, rx_ready});
    end
    checks++;
    if (wr_addr.size() !== 0) begin
      errors++;
      $display("FAIL too_long writes: got %0d required 0", wr_addr.size());
    end
  endtask

  task automatic test_reset_mid_load();
    wr_addr.delete(); wr_data.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    foreach (payload[i]) ;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({cpu_hold, rx_ready, load_done, load_err, mem_we} !== 5'b11000) begin
      errors++;
      $display("FAIL midload_reset: hold/rdy/done/err/we=%b required 11000",
               {cpu_hold, rx_ready, load_done, load_err, mem_we});
    end
    checks++;
    if (wr_addr.size() !== 1 || wr_data[0] !== 32'h44332211) begin
      errors++;
      $display("FAIL midload_first_word: count=%0d data=%h required 1 44332211",
               wr_addr.size(), wr_data[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wr_addr.delete(); wr_data.delete();
    payload = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
    send_frame(16'd2, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr.size() !== 2) begin
      errors++;
      $display("FAIL reload count: got %0d required 2", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEADBEEF ||
          wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h01020304) begin
        errors++;
        $display("FAIL reload words: got %h@%h %h@%h required deadbeef@0 01020304@4",
                 wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
      end
    end
    checks++;
    if ({load_done, cpu_hold} !== 2'b10) begin
      errors++;
      $display("FAIL reload done: done/hold=%b required 10", {load_done, cpu_hold});
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  // XOR of 93 00 B0 00 37 11 00 10 is 8'h15.
  task automatic test_checksum();
    wr_addr.delete(); wr_data.delete();
    load_prog2();
    send_frame(16'd2, 1'b0);
    check_prog2("csum_ok");
    pulse_start();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    foreach (payload[i]) send_byte(payload[i]);
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if ({load_err, cpu_hold, load_done} !== 3'b110) begin
      errors++;
      $display("FAIL csum_bad: err/hold/done=%b required 110", {load_err, cpu_hold, load_done});
    end
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    start    = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    // Bytes offered in DONE must not be consumed.
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_no_accept: rx_ready=%b required 0", rx_ready);
    end
    pulse_start();
    test_junk_and_gaps();
    pulse_start();
    test_zero_len();
    pulse_start();
    test_too_long();
    pulse_start();
    test_reset_mid_load();
`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
